operand_skid_buf: RTL

OPERAND_SKID_BUF -- requirements
Module: operand_skid_buf

---
 rtl/operand_skid_buf.sv | 105 ++++++++++
 1 files changed

// File: rtl/operand_skid_buf.sv
// operand_skid_buf: 2-entry in-order operand FIFO (head + skid register).
// Outputs come straight from the head register; in_ready never sees out_ready.
module operand_skid_buf #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_a,
  input  logic [B_WIDTH-1:0] in_b,
  input  logic [3:0]         in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH-1:0] out_a,
  output logic [B_WIDTH-1:0] out_b,
  output logic [3:0]         out_c,
  output logic [1:0]         count
);

  localparam int W = A_WIDTH + B_WIDTH + 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e         state_q;
  state_e         state_d;
  logic [W-1:0]   head_q;
  logic [W-1:0]   head_d;
  logic [W-1:0]   skid_q;
  logic [W-1:0]   skid_d;
  logic [W-1:0]   in_tuple;
  logic           push;
  logic           pop;

  assign in_tuple  = {in_a, in_b, in_c};

  // Handshake flags depend only on occupancy.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign count     = state_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign out_a = head_q[W-1 -: A_WIDTH];
  assign out_b = head_q[4 +: B_WIDTH];
  assign out_c = head_q[3:0];

  // Next occupancy and data; flush empties without touching data.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_tuple;
            state_d = ONE;
          end
        end
        ONE: begin
          unique case ({push, pop})
            2'b11: head_d = in_tuple;
            2'b10: begin
              skid_d  = in_tuple;
              state_d = FULL;
            end
            2'b01: state_d = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Occupancy and storage registers, cleared by async reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule
